pipe_control: RTL and testbench

- Pipeline control unit for the five-stage Y86-64 core (F/D/E/M/W).
- Each cycle it inspects the D, E, M and W stage fields and generates the stall, bubble and set_CC controls for the pipeline registers, including the set_CC input of pipe_execute.
- It also contains a run-state FSM (IDLE/RUN/STOP) that starts the core, freezes it on an exception or timeout, and latches the final CPU status.
- It keeps saturating performance counters for cycles, load/use stalls, ret stalls and mispredicts.

---
 rtl/y86_pkg.sv | 31 +++
 rtl/pipe_hazard_detect.sv | 30 +++
 rtl/pipe_control.sv | 156 +++++++++++++++
 tb/tb_pipe_control.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings (icode, stat, register ids), the run-state type and the exception test.
// Imported by the pipeline control unit and its hazard detector.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] S_AOK = 4'h1;
    localparam logic [3:0] S_HLT = 4'h2;
    localparam logic [3:0] S_ADR = 4'h3;
    localparam logic [3:0] S_INS = 4'h4;
    localparam logic [3:0] S_TMO = 4'h5;

    localparam logic [3:0] RNONE = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } run_state_t;

    function automatic logic exc(input logic [3:0] s);
        return (s == S_ADR) || (s == S_INS) || (s == S_HLT);
    endfunction

endpackage

// File: rtl/pipe_hazard_detect.sv
// Combinational load/use, ret-in-flight and branch-mispredict detection.
// Zero latency; no state.
module pipe_hazard_detect
    import y86_pkg::*;
(
    input  logic [3:0] i_D_icode,
    input  logic [3:0] i_d_srcA,
    input  logic [3:0] i_d_srcB,
    input  logic [3:0] i_E_icode,
    input  logic [3:0] i_E_dstM,
    input  logic       i_e_Cnd,
    input  logic [3:0] i_M_icode,
    output logic       o_lu,
    output logic       o_rt,
    output logic       o_mp
);

    logic w_e_load;

    assign w_e_load = (i_E_icode == I_MRMOVQ) || (i_E_icode == I_POPQ);

    // RNONE on E_dstM must not match an unused (RNONE) decode source.
    assign o_lu = w_e_load && (i_E_dstM != RNONE) &&
                  ((i_E_dstM == i_d_srcA) || (i_E_dstM == i_d_srcB));

    assign o_rt = (i_D_icode == I_RET) || (i_E_icode == I_RET) || (i_M_icode == I_RET);

    assign o_mp = (i_E_icode == I_JXX) && !i_e_Cnd;

endmodule

// File: rtl/pipe_control.sv
// Y86-64 pipeline control: stall/bubble/set_CC generation, IDLE/RUN/STOP run-state FSM,
// and saturating performance counters. Controls are combinational; state and counters update on clk.
module pipe_control
    import y86_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int TIMEOUT_CYC = 0
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       E_dstM,
    input  logic             e_Cnd,
    input  logic [3:0]       M_icode,
    input  logic [3:0]       m_stat,
    input  logic [3:0]       W_stat,
    output logic             F_stall,
    output logic             D_stall,
    output logic             D_bubble,
    output logic             E_bubble,
    output logic             M_bubble,
    output logic             W_stall,
    output logic             set_CC,
    output logic             halted,
    output logic [3:0]       cpu_stat,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] lu_cnt,
    output logic [CNT_W-1:0] ret_cnt,
    output logic [CNT_W-1:0] mp_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    run_state_t       r_state;
    logic             r_halted;
    logic [3:0]       r_cpu_stat;
    logic [CNT_W-1:0] r_cyc_cnt;
    logic [CNT_W-1:0] r_lu_cnt;
    logic [CNT_W-1:0] r_ret_cnt;
    logic [CNT_W-1:0] r_mp_cnt;

    logic w_lu;
    logic w_rt;
    logic w_mp;
    logic w_m_exc;
    logic w_w_exc;
    logic w_timeout;
    logic w_run;

    pipe_hazard_detect u_hazard (
        .i_D_icode (D_icode),
        .i_d_srcA  (d_srcA),
        .i_d_srcB  (d_srcB),
        .i_E_icode (E_icode),
        .i_E_dstM  (E_dstM),
        .i_e_Cnd   (e_Cnd),
        .i_M_icode (M_icode),
        .o_lu      (w_lu),
        .o_rt      (w_rt),
        .o_mp      (w_mp)
    );

    assign w_m_exc   = exc(m_stat);
    assign w_w_exc   = exc(W_stat);
    assign w_run     = (r_state == ST_RUN);
    assign w_timeout = (TIMEOUT_CYC != 0) && (r_cyc_cnt == CNT_W'(TIMEOUT_CYC - 1));

    // Exception is checked first so a simultaneous timeout reports the real W status.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_halted   <= 1'b0;
            r_cpu_stat <= S_AOK;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) r_state <= ST_RUN;
                end
                ST_RUN: begin
                    if (w_w_exc) begin
                        r_state    <= ST_STOP;
                        r_halted   <= 1'b1;
                        r_cpu_stat <= W_stat;
                    end else if (w_timeout) begin
                        r_state    <= ST_STOP;
                        r_halted   <= 1'b1;
                        r_cpu_stat <= S_TMO;
                    end
                end
                default: r_state <= ST_STOP;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cyc_cnt <= '0;
            r_lu_cnt  <= '0;
            r_ret_cnt <= '0;
            r_mp_cnt  <= '0;
        end else if (w_run) begin
            if (r_cyc_cnt != CNT_MAX)          r_cyc_cnt <= r_cyc_cnt + CNT_ONE;
            if (w_lu && r_lu_cnt != CNT_MAX)   r_lu_cnt  <= r_lu_cnt + CNT_ONE;
            if (w_rt && !w_lu && r_ret_cnt != CNT_MAX) r_ret_cnt <= r_ret_cnt + CNT_ONE;
            if (w_mp && r_mp_cnt != CNT_MAX)   r_mp_cnt  <= r_mp_cnt + CNT_ONE;
        end
    end

    // IDLE drains the pipe with bubbles; STOP freezes every architectural register.
    always_comb begin
        F_stall  = 1'b0;
        D_stall  = 1'b0;
        D_bubble = 1'b0;
        E_bubble = 1'b0;
        M_bubble = 1'b0;
        W_stall  = 1'b0;
        set_CC   = 1'b0;
        case (r_state)
            ST_RUN: begin
                F_stall  = w_lu | w_rt;
                D_stall  = w_lu;
                D_bubble = w_mp | (w_rt & ~w_lu);
                E_bubble = w_mp | w_lu;
                M_bubble = w_m_exc | w_w_exc;
                W_stall  = w_w_exc;
                set_CC   = (E_icode == I_OPQ) & ~w_m_exc & ~w_w_exc;
            end
            ST_STOP: begin
                F_stall  = 1'b1;
                D_stall  = 1'b1;
                E_bubble = 1'b1;
                M_bubble = 1'b1;
                W_stall  = 1'b1;
            end
            default: begin
                F_stall  = 1'b1;
                D_bubble = 1'b1;
                E_bubble = 1'b1;
                M_bubble = 1'b1;
            end
        endcase
    end

    assign halted   = r_halted;
    assign cpu_stat = r_cpu_stat;
    assign cyc_cnt  = r_cyc_cnt;
    assign lu_cnt   = r_lu_cnt;
    assign ret_cnt  = r_ret_cnt;
    assign mp_cnt   = r_mp_cnt;

endmodule

// File: tb/tb_pipe_control.sv
// Directed bench for pipe_control with a short timeout so every run-state exit is reachable.
module tb_pipe_control;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode, m_stat, W_stat;
    logic        e_Cnd;
    logic        F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_CC, halted;
    logic [3:0]  cpu_stat;
    logic [31:0] cyc_cnt, lu_cnt, ret_cnt, mp_cnt;
    logic [6:0]  ctrl;

    int total = 0;
    int bad   = 0;

    // {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_CC}
    localparam logic [6:0] C_IDLE = 7'b1011100;
    localparam logic [6:0] C_STOP = 7'b1101110;
    localparam logic [6:0] C_NONE = 7'b0000000;

    always #5 clk = ~clk;

    assign ctrl = {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_CC};

    pipe_control #(.CNT_W(32), .TIMEOUT_CYC(8)) dut (
        .clk(clk), .rst(rst), .start(start),
        .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd),
        .M_icode(M_icode), .m_stat(m_stat), .W_stat(W_stat),
        .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
        .E_bubble(E_bubble), .M_bubble(M_bubble), .W_stall(W_stall),
        .set_CC(set_CC), .halted(halted), .cpu_stat(cpu_stat),
        .cyc_cnt(cyc_cnt), .lu_cnt(lu_cnt), .ret_cnt(ret_cnt), .mp_cnt(mp_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic quiet_inputs();
        D_icode = 4'h1; d_srcA = 4'hF; d_srcB = 4'hF;
        E_icode = 4'h1; E_dstM = 4'hF; e_Cnd = 1'b0;
        M_icode = 4'h1; m_stat = 4'h1; W_stat = 4'h1;
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        quiet_inputs();
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        quiet_inputs();
        #1;
        check("rst_ctrl", 32'(ctrl), 32'(C_IDLE));
        check("rst_halted", 32'(halted), 0);
        check("rst_stat", 32'(cpu_stat), 1);
        check("rst_cyc", cyc_cnt, 0);
        #11;
        rst = 1'b0;

        // Idle without start: bubbles only, no cycle counting.
        tick(10);
        #1;
        check("idle_ctrl", 32'(ctrl), 32'(C_IDLE));
        check("idle_cyc", cyc_cnt, 0);

        pulse_start();
        #1;
        check("run_ctrl", 32'(ctrl), 32'(C_NONE));
        check("run_cyc0", cyc_cnt, 0);
        tick(1); #1;
        check("run_cyc1", cyc_cnt, 1);
        tick(1); #1;
        check("run_cyc2", cyc_cnt, 2);

        // Load/use on srcA, then the same load with no matching source.
        E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3;
        #1;
        check("lu_ctrl", 32'(ctrl), 32'(7'b1101000));
        tick(1); #1;
        check("lu_cnt", lu_cnt, 1);
        d_srcA = 4'hF;
        #1;
        check("lu_none_ctrl", 32'(ctrl), 32'(C_NONE));
        d_srcB = 4'h3;
        #1;
        check("lu_srcB_ctrl", 32'(ctrl), 32'(7'b1101000));

        // Asynchronous reset mid-RUN.
        rst = 1'b1;
        #1;
        check("arst_ctrl", 32'(ctrl), 32'(C_IDLE));
        check("arst_cyc", cyc_cnt, 0);
        check("arst_lu", lu_cnt, 0);
        rst = 1'b0;
        quiet_inputs();

        pulse_start();
        D_icode = 4'h9;
        #1;
        check("ret_ctrl", 32'(ctrl), 32'(7'b1010000));
        tick(1);
        D_icode = 4'h1;
        #1;
        check("ret_cnt", ret_cnt, 1);
        E_icode = 4'h7; e_Cnd = 1'b0;
        #1;
        check("mp_ctrl", 32'(ctrl), 32'(7'b0011000));
        tick(1);
        e_Cnd = 1'b1;
        #1;
        check("mp_cnt", mp_cnt, 1);
        check("taken_ctrl", 32'(ctrl), 32'(C_NONE));
        tick(1);
        E_icode = 4'h6;
        #1;
        check("mp_cnt_hold", mp_cnt, 1);
        check("setcc_ctrl", 32'(ctrl), 32'(7'b0000001));
        m_stat = 4'h3;
        #1;
        check("setcc_mexc_ctrl", 32'(ctrl), 32'(7'b0000100));

        // Halt reaching writeback: W_stall this cycle, STOP after the edge.
        E_icode = 4'h1; m_stat = 4'h1; W_stat = 4'h2;
        #1;
        check("hlt_ctrl", 32'(ctrl), 32'(7'b0000110));
        tick(1); #1;
        check("hlt_halted", 32'(halted), 1);
        check("hlt_stat", 32'(cpu_stat), 2);
        check("hlt_ctrl_stop", 32'(ctrl), 32'(C_STOP));
        check("hlt_cyc", cyc_cnt, 4);
        D_icode = 4'h9;
        W_stat = 4'h1;
        pulse_start();
        tick(1); #1;
        check("stop_cyc_hold", cyc_cnt, 4);
        check("stop_ret_hold", ret_cnt, 1);
        check("stop_start_ign", 32'(halted), 1);
        check("stop_ctrl_hold", 32'(ctrl), 32'(C_STOP));
        check("stop_stat_hold", 32'(cpu_stat), 2);

        // Timeout after 8 RUN cycles.
        apply_reset();
        #1;
        check("tmo_rst_halted", 32'(halted), 0);
        pulse_start();
        tick(7); #1;
        check("tmo_pre_halted", 32'(halted), 0);
        check("tmo_pre_cyc", cyc_cnt, 7);
        tick(1); #1;
        check("tmo_halted", 32'(halted), 1);
        check("tmo_stat", 32'(cpu_stat), 5);
        check("tmo_cyc", cyc_cnt, 8);

        // Exception on the timeout cycle wins.
        apply_reset();
        pulse_start();
        tick(7);
        W_stat = 4'h4;
        #1;
        check("tmo_exc_pre", 32'(halted), 0);
        tick(1); #1;
        check("tmo_exc_halted", 32'(halted), 1);
        check("tmo_exc_stat", 32'(cpu_stat), 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
